// File: rtl/half_wave_rectifier.sv
// Clocked half-wave rectifier for a signed sample stream, with positive
// half-cycle status, per-half-cycle peak tracking and rising zero-crossing count.
module half_wave_rectifier #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic signed [DATA_W-1:0] sine_wave,
    output logic        [DATA_W-1:0] rectified_wave,
    output logic                     pos_half,
    output logic        [DATA_W-1:0] peak,
    output logic        [CNT_W-1:0]  half_cycles
);

    logic [DATA_W-1:0] rect_q, rect_d;
    logic              pos_q, pos_d;
    logic [DATA_W-1:0] peak_q, peak_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] sample_u;
    logic              sample_pos;

    // Zero is treated as non-positive: it never opens a half cycle.
    function automatic logic is_positive(input logic signed [DATA_W-1:0] s);
        return (s[DATA_W-1] == 1'b0) && (s != '0);
    endfunction

    function automatic logic [DATA_W-1:0] rectify(input logic signed [DATA_W-1:0] s);
        return s[DATA_W-1] ? '0 : $unsigned(s);
    endfunction

    always_comb begin
        sample_u   = $unsigned(sine_wave);
        sample_pos = is_positive(sine_wave);
        rect_d     = rectify(sine_wave);
        pos_d      = sample_pos;
        peak_d     = peak_q;
        cnt_d      = cnt_q;
        if (sample_pos) begin
            if (!pos_q) begin
                // Rising crossing restarts the peak for the new half cycle.
                peak_d = sample_u;
                cnt_d  = cnt_q + CNT_W'(1);
            end else if (sample_u > peak_q) begin
                peak_d = sample_u;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rect_q <= '0;
            pos_q  <= 1'b0;
            peak_q <= '0;
            cnt_q  <= '0;
        end else begin
            rect_q <= rect_d;
            pos_q  <= pos_d;
            peak_q <= peak_d;
            cnt_q  <= cnt_d;
        end
    end

    assign rectified_wave = rect_q;
    assign pos_half       = pos_q;
    assign peak           = peak_q;
    assign half_cycles    = cnt_q;

endmodule

// File: tb/tb_half_wave_rectifier.sv
// Directed-vector bench for half_wave_rectifier: a default-width instance plus
// a 4-bit-counter instance used to exercise counter wrap.
module tb_half_wave_rectifier;

    logic              clk;
    logic              rst;
    logic signed [7:0] sine;

    logic [7:0]  rect;
    logic        pos;
    logic [7:0]  pk;
    logic [15:0] hc;

    logic [7:0]  w_rect;
    logic        w_pos;
    logic [7:0]  w_pk;
    logic [3:0]  w_hc;

    int checks = 0;
    int errors = 0;

    half_wave_rectifier #(.DATA_W(8), .CNT_W(16)) u_dut (
        .clk(clk), .rst(rst), .sine_wave(sine),
        .rectified_wave(rect), .pos_half(pos), .peak(pk), .half_cycles(hc)
    );

    half_wave_rectifier #(.DATA_W(8), .CNT_W(4)) u_wrap (
        .clk(clk), .rst(rst), .sine_wave(sine),
        .rectified_wave(w_rect), .pos_half(w_pos), .peak(w_pk), .half_cycles(w_hc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive a sample, let one rising edge capture it, then settle 1 time unit.
    task automatic step(input logic [7:0] v);
        sine = v;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        #2 rst = 1'b1;
        sine = 8'h00;
        @(posedge clk);
        #3 rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        step(8'h55);
        checks++;
        if (rect !== 8'h55 || pk !== 8'h55 || hc !== 16'd1 || pos !== 1'b1) begin
            errors++;
            $display("FAIL reset_pre: rect=%h pk=%h hc=%0d pos=%b, want 55 55 1 1", rect, pk, hc, pos);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (rect !== 8'h00 || pk !== 8'h00 || hc !== 16'd0 || pos !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: rect=%h pk=%h hc=%0d pos=%b, want all 0", rect, pk, hc, pos);
        end
        @(posedge clk);
        #1;
        checks++;
        if (rect !== 8'h00 || pk !== 8'h00 || hc !== 16'd0 || pos !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold: rect=%h pk=%h hc=%0d pos=%b, want all 0", rect, pk, hc, pos);
        end
        #2 rst = 1'b0;
        sine = 8'h00;
        for (int i = 0; i < 2; i++) begin
            step(8'h00);
            checks++;
            if (rect !== 8'h00 || pk !== 8'h00 || hc !== 16'd0 || pos !== 1'b0) begin
                errors++;
                $display("FAIL reset_zero%0d: rect=%h pk=%h hc=%0d pos=%b, want all 0", i, rect, pk, hc, pos);
            end
        end
    endtask

    task automatic test_basic();
        logic [7:0] vin  [3] = '{8'h55, 8'hDB, 8'h00};
        logic [7:0] vout [3] = '{8'h55, 8'h00, 8'h00};
        logic       vpos [3] = '{1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 3; i++) begin
            step(vin[i]);
            checks++;
            if (rect !== vout[i] || pos !== vpos[i]) begin
                errors++;
                $display("FAIL basic%0d: in=%h rect=%h pos=%b, want %h %b", i, vin[i], rect, pos, vout[i], vpos[i]);
            end
        end
    endtask

    task automatic test_extremes();
        logic [7:0] vin  [4] = '{8'h7F, 8'h80, 8'h01, 8'hFF};
        logic [7:0] vout [4] = '{8'h7F, 8'h00, 8'h01, 8'h00};
        logic       vpos [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            step(vin[i]);
            checks++;
            if (rect !== vout[i] || pos !== vpos[i]) begin
                errors++;
                $display("FAIL extreme%0d: in=%h rect=%h pos=%b, want %h %b", i, vin[i], rect, pos, vout[i], vpos[i]);
            end
        end
    endtask

    task automatic test_peak_crossing();
        logic [7:0]  vin [6] = '{8'h00, 8'h10, 8'h40, 8'h20, 8'hE0, 8'h05};
        logic [7:0]  vpk [6] = '{8'h00, 8'h10, 8'h40, 8'h40, 8'h40, 8'h05};
        logic [15:0] vhc [6] = '{16'd0, 16'd1, 16'd1, 16'd1, 16'd1, 16'd2};
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            step(vin[i]);
            checks++;
            if (pk !== vpk[i] || hc !== vhc[i]) begin
                errors++;
                $display("FAIL peak%0d: in=%h peak=%h hc=%0d, want %h %0d", i, vin[i], pk, hc, vpk[i], vhc[i]);
            end
        end
    endtask

    task automatic test_wrap();
        apply_reset();
        for (int i = 1; i <= 16; i++) begin
            step(8'h10);
            if (i == 15) begin
                checks++;
                if (w_hc !== 4'd15) begin
                    errors++;
                    $display("FAIL wrap_15: hc=%0d, want 15", w_hc);
                end
            end
            if (i == 16) begin
                checks++;
                if (w_hc !== 4'd0 || hc !== 16'd16) begin
                    errors++;
                    $display("FAIL wrap_0: hc4=%0d hc16=%0d, want 0 16", w_hc, hc);
                end
            end
            step(8'hF0);
        end
        checks++;
        if (w_pk !== 8'h10 || w_pos !== 1'b0 || w_rect !== 8'h00) begin
            errors++;
            $display("FAIL wrap_hold: peak=%h pos=%b rect=%h, want 10 0 00", w_pk, w_pos, w_rect);
        end
    endtask

    task automatic test_glitch();
        #1 sine = 8'h30;
        #1 sine = 8'h70;
        #1 sine = 8'h05;
        #1;
        checks++;
        if (rect !== 8'h00 || pos !== 1'b0 || pk !== 8'h10 || hc !== 16'd16) begin
            errors++;
            $display("FAIL glitch_hold: rect=%h pos=%b peak=%h hc=%0d, want 00 0 10 16", rect, pos, pk, hc);
        end
        step(8'h22);
        checks++;
        if (rect !== 8'h22 || pos !== 1'b1 || pk !== 8'h22 || hc !== 16'd17) begin
            errors++;
            $display("FAIL glitch_edge: rect=%h pos=%b peak=%h hc=%0d, want 22 1 22 17", rect, pos, pk, hc);
        end
    endtask

    initial begin
        rst  = 1'b1;
        sine = 8'h00;
        @(posedge clk);
        #3 rst = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_extremes();
        test_peak_crossing();
        test_wrap();
        test_glitch();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
